alu_exec_unit: RTL and testbench

Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Accepts an operation and two operands over a valid/ready handshake.
- Computes single-cycle logic/arithmetic ops and an iterative shift-add multiply.
- Returns a registered result and zero flag over a second valid/ready handshake.
- Sits in the EX stage between the operand muxes and the EX/MEM register; the control unit stalls on in_ready low.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_seq.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 113 +++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code constants used by both the ALU control
// decoder and the execution unit, plus the execution unit state encoding.
package alu_pkg;

    localparam int ALU_CTL_W = 3;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT  = 3'b010;
    localparam logic [ALU_CTL_W-1:0] ALU_MUL  = 3'b011;
    localparam logic [ALU_CTL_W-1:0] ALU_NOR  = 3'b100;
    localparam logic [ALU_CTL_W-1:0] ALU_AND  = 3'b101;
    localparam logic [ALU_CTL_W-1:0] ALU_OR   = 3'b110;
    localparam logic [ALU_CTL_W-1:0] ALU_RSVD = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock.
// done and product are combinational on the final step so the owner can
// register the product on the same edge the last step retires, giving a
// total latency of WIDTH cycles from start.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             running;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;

    // Accumulator value after the current step's conditional add.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = running && (count == CNT_W'(1));
    assign product = acc_next;

    // Step sequencer: count is a down-counter terminating at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= CNT_W'(WIDTH);
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: valid/ready operation intake, single-cycle
// datapath, sequential multiply and a registered result with zero/illegal.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | accepting ops; single-cycle results retire here (latency 1)
//  MUL   | shift-add multiply in progress, intake stalled, busy=1
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    import alu_pkg::*;

    alu_state_e       state;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] sc_result;
    logic             sc_illegal;

    // New work only when idle and the output slot is free or draining now.
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_ctl == ALU_MUL);

    // Single-cycle datapath; MUL lanes here are don't-care and never retired.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (alu_ctl)
            ALU_ADD: sc_result = op_a + op_b;
            ALU_SUB: sc_result = op_a - op_b;
            ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_AND: sc_result = op_a & op_b;
            ALU_OR:  sc_result = op_a | op_b;
            ALU_NOR: sc_result = ~(op_a | op_b);
            ALU_MUL: sc_result = '0;
            default: begin
                sc_result  = '0;
                sc_illegal = 1'b1;
            end
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Control FSM and output register; outputs hold while unconsumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_ctl == ALU_MUL) begin
                            state     <= MUL;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            result    <= sc_result;
                            zero      <= (sc_result == '0);
                            illegal   <= sc_illegal;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus
// hand-written sequences for multiply, backpressure and reset abort.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an op at the negedge and drop in_valid just after the accepting edge.
    task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_ctl  = ctl;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accepting edge of a MUL; checks latency and product.
    task automatic wait_mul(input string name, input logic [31:0] exp_res);
        int n;
        logic stall_ok;
        n = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        chk({name, " busy after accept"}, {31'b0, busy}, 32'd1);
        chk({name, " in_ready after accept"}, {31'b0, in_ready}, 32'd0);
        chk({name, " out_valid low while busy"}, {31'b0, out_valid}, 32'd0);
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
            if (!busy || in_ready) stall_ok = 1'b0;
        end
        chk({name, " latency"}, n, 32'd32);
        chk({name, " stall held"}, {31'b0, stall_ok}, 32'd1);
        chk({name, " result"}, result, exp_res);
        chk({name, " zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
        chk({name, " illegal"}, {31'b0, illegal}, 32'd0);
        chk({name, " busy cleared"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",       3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1]  = '{"sub_eq",    3'b001, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0};
        vecs[2]  = '{"slt_neg",   3'b010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[3]  = '{"slt_swap",  3'b010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
        vecs[4]  = '{"add_wrap",  3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
        vecs[5]  = '{"sub_neg",   3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[6]  = '{"and",       3'b101, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
        vecs[7]  = '{"or",        3'b110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0};
        vecs[8]  = '{"rsvd",      3'b111, 32'd123,      32'd456,      32'd0,        1'b1, 1'b1};
        vecs[9]  = '{"nor_zero",  3'b100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{"nor_mix",   3'b100, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_ctl   = 3'b000;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst result",    result,             32'd0);
        chk("rst zero",      {31'b0, zero},      32'd0);
        chk("rst illegal",   {31'b0, illegal},   32'd0);
        chk("rst busy",      {31'b0, busy},      32'd0);
        chk("rst in_ready",  {31'b0, in_ready},  32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].ctl, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk({vecs[i].name, " out_valid"}, {31'b0, out_valid}, 32'd1);
            chk({vecs[i].name, " result"},    result,             vecs[i].res);
            chk({vecs[i].name, " zero"},      {31'b0, zero},      {31'b0, vecs[i].z});
            chk({vecs[i].name, " illegal"},   {31'b0, illegal},   {31'b0, vecs[i].ill});
        end

        issue(3'b011, 32'd7, 32'd6);
        wait_mul("mul7x6", 32'd42);
        issue(3'b011, 32'h00010000, 32'h00010000);
        wait_mul("mul_ovf", 32'd0);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_mul("mul_ones", 32'd1);

        // Backpressure: result held, intake blocked, then drain with a same-cycle new op.
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'b101, 32'h0000F0F0, 32'h0000FF00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp result",    result,             32'h0000F000);
            chk("bp in_ready",  {31'b0, in_ready},  32'd0);
            if (k < 2) @(posedge clk);
        end
        out_ready = 1'b1;
        alu_ctl   = 3'b110;
        op_a      = 32'h00001234;
        op_b      = 32'h00004300;
        in_valid  = 1'b1;
        #1;
        chk("drain in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b out_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b result",    result,             32'h00005334);

        // MUL accepted in the same cycle the OR result drains.
        alu_ctl  = 3'b011;
        op_a     = 32'd3;
        op_b     = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_mul("mul_drain", 32'd12);

        @(posedge clk);
        @(negedge clk);
        chk("idle out_valid clear", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of a multiply aborts it.
        issue(3'b011, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort busy",      {31'b0, busy},      32'd0);
        chk("abort in_ready",  {31'b0, in_ready},  32'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid || busy) seen = 1'b1;
            end
            chk("abort no stale result", {31'b0, seen}, 32'd0);
        end

        issue(3'b000, 32'd100, 32'd23);
        @(negedge clk);
        chk("post abort add", result, 32'd123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
